mem_assem_arbiter: RTL and testbench
====================================

Name: mem_assem_arbiter

Overview:
- Packet-level round-robin arbiter that merges the assembled-MEM streams of N_LANES parallel MEM-assembly lanes onto one AXI4-Stream toward the downstream chaining stage.
- Each lane emits one packet per read: its MEM records, with tlast on the final record.
- Once a lane is granted, it holds the output until its tlast beat, so records of different reads never interleave.
- The output carries a lane tag, a per-packet beat-length guard and packet statistics.

Parameters:
- N_LANES, 4, number of requesting lanes (2..16).
- DATA_W, 128, width of one assembled-MEM record.
- MAX_BEATS, 256, maximum records per packet before a forced terminate.
- CNT_W, 32, width of the packet statistics counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  N_LANES*DATA_W  lane records; lane k occupies bits [k*DATA_W +: DATA_W].
- s_tvalid  in  N_LANES  per-lane valid.
- s_tlast  in  N_LANES  per-lane end of packet.
- s_tready  out  N_LANES  per-lane ready.
- m_tdata  out  DATA_W  merged record.
- m_tvalid  out  1  merged valid.
- m_tlast  out  1  merged end of packet (source tlast OR forced).
- m_tid  out  $clog2(N_LANES)  lane index of the current packet.
- m_tready  in  1  downstream ready.
- err_overlen  out  1  sticky: a packet exceeded MAX_BEATS.
- pkt_cnt  out  CNT_W  packets completed since reset.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - err_overlen=0, pkt_cnt=0, m_tid=0.
  - m_tvalid=0, all s_tready=0.
- A reset during a packet abandons it. The downstream stage must tolerate the missing tlast. Any remaining source beats are arbitrated as a new packet after reset.
- States: IDLE, LOCKED.
- IDLE:
  - m_tvalid=0 and s_tready=0 throughout.
  - If any s_tvalid is high, pick the first valid lane at or after rr_ptr, searching upward with wrap-around.
  - Register that lane into grant and m_tid, clear beat_cnt, go to LOCKED.
  - Arbitration costs exactly 1 cycle of bubble per packet.
- LOCKED (combinational pass-through of the granted lane):
  - m_tdata = s_tdata[grant] and m_tvalid = s_tvalid[grant].
  - s_tready[grant] = m_tready; every other s_tready is 0.
  - No buffering: zero added latency within a packet, and back-pressure passes straight through.
- Beat: m_tvalid & m_tready. Each beat increments beat_cnt (width $clog2(MAX_BEATS+1)).
- Forced tlast: m_tlast = s_tlast[grant] | (beat_cnt == MAX_BEATS-1).
- A beat with m_tlast=1 ends the packet:
  - pkt_cnt += 1, wrapping at 2^CNT_W.
  - rr_ptr = grant+1 mod N_LANES.
  - Go to IDLE.
- If the terminate was forced (source tlast=0): set err_overlen, held until reset. The source lane's remaining beats then arrive as a new packet.
- A source tlast on exactly beat MAX_BEATS is legal and does not set err_overlen.
- Lanes not granted see s_tready=0 and must hold their data (AXI rule). Deasserting s_tvalid without a handshake is tolerated: m_tvalid simply drops.
- A single-beat packet (tlast on the first beat) is legal: 1 beat, then IDLE.
- Fairness: no lane waits more than N_LANES-1 packets while continuously valid.
- m_tid is stable for the whole packet.

Test Plan:
- Single lane: lane 2 sends 3 beats (D0..D2, tlast on D2) with m_tready=1.
  - m_tid=2 for all beats.
  - Beats appear on cycles 1..3 after s_tvalid rises.
  - m_tlast only on D2; pkt_cnt=1.
- Round-robin: all 4 lanes continuously valid, each sending 2-beat packets.
  - Output lane order is 0,1,2,3,0,…
  - Exactly 1 idle cycle between packets.
  - No interleaving of beats from different lanes.
- Back-pressure: toggle m_tready 1,0,1,0 during a 4-beat lane-1 packet.
  - s_tready[1] tracks m_tready exactly; other s_tready stay 0.
  - Data order is preserved and no beat is dropped or duplicated.
- Overlength: MAX_BEATS=4, lane 0 sends 6 beats with tlast on beat 6.
  - Beat 4 has m_tlast=1 and err_overlen sets.
  - Beats 5..6 emerge as a second packet: m_tid=0, tlast on beat 6.
  - pkt_cnt=2.
- Exact length: MAX_BEATS=4, lane 3 sends 4 beats with tlast on beat 4 → one packet, err_overlen remains 0.
- Reset mid-packet: assert rst between cycle edges after beat 2 of 5.
  - m_tvalid and s_tready go low immediately (asynchronously).
  - pkt_cnt=0 and rr_ptr=0.
  - After release, lane 0's remaining beats are granted as a new packet.

Source files
------------

// File: rtl/mem_assem_arbiter_if.sv
// Stream bundle between the MEM-assembly lanes, the packet arbiter and the chaining stage.
// The slave modport is the arbiter's view. The master modport is the surrounding environment.
interface mem_assem_arbiter_if #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 128
);
    localparam int ID_W = $clog2(N_LANES);

    logic [N_LANES*DATA_W-1:0] s_tdata;
    logic [N_LANES-1:0]        s_tvalid;
    logic [N_LANES-1:0]        s_tlast;
    logic [N_LANES-1:0]        s_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tvalid;
    logic                      m_tlast;
    logic [ID_W-1:0]           m_tid;
    logic                      m_tready;

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
endinterface

// File: rtl/mem_assem_arbiter.sv
// Packet-level round-robin merge of N_LANES assembled-MEM streams onto one stream.
// A granted lane keeps the output until its tlast or until the beat guard forces a terminate.
module mem_assem_arbiter #(
    parameter int N_LANES   = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_assem_arbiter_if.slave   bus,
    output logic                 err_overlen,
    output logic [CNT_W-1:0]     pkt_cnt
);
    localparam int ID_W = $clog2(N_LANES);
    localparam int BC_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [BC_W-1:0]   beat_cnt_q;
    logic [BC_W-1:0]   beat_cnt_d;
    logic              err_q;
    logic [CNT_W-1:0]  pkt_cnt_q;

    logic [DATA_W-1:0] lane_data_s [N_LANES];
    logic [ID_W-1:0]   pick_s;
    logic [ID_W-1:0]   next_ptr_s;
    logic              locked_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic              forced_s;
    logic              m_tvalid_s;
    logic              m_tlast_s;
    logic              beat_s;
    logic [N_LANES-1:0] s_tready_s;

    // First requesting lane at or after ptr, searching upward with wrap-around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_LANES-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_LANES) begin
                idx = idx - N_LANES;
            end else begin
                idx = idx;
            end
            if (!found && req[ID_W'(idx)]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign lane_data_s[k] = bus.s_tdata[k*DATA_W +: DATA_W];
    end

    // Pass-through mux of the granted lane plus the beat/terminate decode.
    always_comb begin
        locked_s    = (state_q == LOCKED);
        sel_valid_s = bus.s_tvalid[grant_q];
        sel_last_s  = bus.s_tlast[grant_q];
        forced_s    = (beat_cnt_q == BC_W'(MAX_BEATS - 1));
        m_tvalid_s  = locked_s & sel_valid_s;
        m_tlast_s   = locked_s & (sel_last_s | forced_s);
        beat_s      = m_tvalid_s & bus.m_tready;
        beat_cnt_d  = beat_cnt_q + BC_W'(1);
        pick_s      = rr_pick(bus.s_tvalid, rr_ptr_q);
        s_tready_s  = '0;
        if (locked_s) begin
            s_tready_s[grant_q] = bus.m_tready;
        end else begin
            s_tready_s = '0;
        end
        if (grant_q == ID_W'(N_LANES - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_q + ID_W'(1);
        end
    end

    assign bus.m_tdata  = lane_data_s[grant_q];
    assign bus.m_tvalid = m_tvalid_s;
    assign bus.m_tlast  = m_tlast_s;
    assign bus.m_tid    = grant_q;
    assign bus.s_tready = s_tready_s;
    assign err_overlen  = err_q;
    assign pkt_cnt      = pkt_cnt_q;

    // Arbitration FSM: grant on the IDLE bubble cycle, release on the terminating beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.s_tvalid) begin
                        grant_q    <= pick_s;
                        beat_cnt_q <= '0;
                        state_q    <= LOCKED;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                LOCKED: begin
                    if (beat_s) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (m_tlast_s) begin
                            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                            rr_ptr_q  <= next_ptr_s;
                            state_q   <= IDLE;
                            // A terminate without source tlast means the guard cut the packet.
                            if (!sel_last_s) begin
                                err_q <= 1'b1;
                            end else begin
                                err_q <= err_q;
                            end
                        end else begin
                            state_q <= LOCKED;
                        end
                    end else begin
                        state_q <= LOCKED;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_assem_arbiter.sv
// Directed bench for mem_assem_arbiter: scripted lane sources, output beat capture, inline checks.
module tb_mem_assem_arbiter;
    localparam int NL = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_overlen;
    logic [CW-1:0] pkt_cnt;

    always #5 clk = ~clk;

    mem_assem_arbiter_if #(.N_LANES(NL), .DATA_W(DW)) bus ();

    mem_assem_arbiter #(.N_LANES(NL), .DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_overlen(err_overlen), .pkt_cnt(pkt_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int base     = 0;

    logic [DW-1:0] src_data [NL][8];
    logic          src_last [NL][8];
    int            src_len  [NL];
    int            src_pos  [NL];

    int            obs_cyc  [$];
    logic [DW-1:0] obs_data [$];
    logic          obs_last [$];
    logic [1:0]    obs_tid  [$];
    logic          obs_err  [$];

    // Lane k sends len beats with data {k, beat index}; bit i of last_mask marks tlast on beat i.
    task automatic load(input int lane, input int len, input int last_mask);
        for (int i = 0; i < len; i++) begin
            src_data[lane][i] = DW'(lane * 4096 + i);
            src_last[lane][i] = last_mask[i];
        end
        src_len[lane] = len;
        src_pos[lane] = 0;
    endtask

    task automatic drive_lanes();
        for (int k = 0; k < NL; k++) begin
            if (src_pos[k] < src_len[k]) begin
                bus.s_tvalid[k]            = 1'b1;
                bus.s_tdata[k*DW +: DW]    = src_data[k][src_pos[k]];
                bus.s_tlast[k]             = src_last[k][src_pos[k]];
            end else begin
                bus.s_tvalid[k]            = 1'b0;
                bus.s_tdata[k*DW +: DW]    = '0;
                bus.s_tlast[k]             = 1'b0;
            end
        end
    endtask

    task automatic clear_obs();
        obs_cyc.delete(); obs_data.delete(); obs_last.delete();
        obs_tid.delete(); obs_err.delete();
    endtask

    // Capture this cycle's output beat, cross the edge, then advance handshaken sources.
    task automatic cycle();
        logic [NL-1:0] hs;
        if (bus.m_tvalid && bus.m_tready) begin
            obs_cyc.push_back(cyc - base);
            obs_data.push_back(bus.m_tdata);
            obs_last.push_back(bus.m_tlast);
            obs_tid.push_back(bus.m_tid);
            obs_err.push_back(err_overlen);
        end
        hs = bus.s_tvalid & bus.s_tready;
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (hs[k]) src_pos[k] = src_pos[k] + 1;
        end
        drive_lanes();
        cyc = cyc + 1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NL; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive_lanes();
        bus.m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        clear_obs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_tready = 1'b1;
        for (int k = 0; k < NL; k++) load(k, 2, 2);
        drive_lanes();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b expected 0", bus.m_tvalid); else n_pass++;
        n_checks++; if (bus.s_tready !== 4'b0000) $display("FAIL rst_s_tready: got %b expected 0000", bus.s_tready); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL rst_pkt_cnt: got %0d expected 0", pkt_cnt); else n_pass++;
        n_checks++; if (err_overlen !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_overlen); else n_pass++;
        n_checks++; if (bus.m_tid !== 2'd0) $display("FAIL rst_m_tid: got %0d expected 0", bus.m_tid); else n_pass++;
    endtask

    task automatic test_single_lane();
        do_reset();
        load(2, 3, 4);
        drive_lanes();
        #1;
        base = cyc;
        repeat (6) cycle();
        n_checks++;
        if (obs_data.size() !== 3) begin
            $display("FAIL sl_count: got %0d expected 3", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (obs_tid[i] !== 2'd2) $display("FAIL sl_tid[%0d]: got %0d expected 2", i, obs_tid[i]); else n_pass++;
                n_checks++; if (obs_data[i] !== DW'(16'h2000 + i)) $display("FAIL sl_data[%0d]: got %h expected %h", i, obs_data[i], 16'h2000 + i); else n_pass++;
                n_checks++; if (obs_last[i] !== (i == 2)) $display("FAIL sl_last[%0d]: got %b expected %b", i, obs_last[i], (i == 2)); else n_pass++;
                n_checks++; if (obs_cyc[i] !== i + 1) $display("FAIL sl_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], i + 1); else n_pass++;
            end
        end
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL sl_pkt_cnt: got %0d expected 1", pkt_cnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < NL; k++) load(k, 4, 10);
        drive_lanes();
        #1;
        base = cyc;
        repeat (26) cycle();
        n_checks++;
        if (obs_data.size() !== 16) begin
            $display("FAIL rr_count: got %0d expected 16", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 16; i++) begin
                int lane;
                lane = (i / 2) % 4;
                n_checks++; if (obs_tid[i] !== 2'(lane)) $display("FAIL rr_tid[%0d]: got %0d expected %0d", i, obs_tid[i], lane); else n_pass++;
                n_checks++; if (obs_data[i] !== DW'(lane * 4096 + (i / 8) * 2 + i % 2)) $display("FAIL rr_data[%0d]: got %h expected %h", i, obs_data[i], lane * 4096 + (i / 8) * 2 + i % 2); else n_pass++;
                n_checks++; if (obs_last[i] !== (i % 2 == 1)) $display("FAIL rr_last[%0d]: got %b expected %b", i, obs_last[i], (i % 2 == 1)); else n_pass++;
                n_checks++; if (obs_cyc[i] !== 1 + 3 * (i / 2) + i % 2) $display("FAIL rr_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], 1 + 3 * (i / 2) + i % 2); else n_pass++;
            end
        end
        n_checks++; if (pkt_cnt !== 32'd8) $display("FAIL rr_pkt_cnt: got %0d expected 8", pkt_cnt); else n_pass++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        load(1, 4, 8);
        drive_lanes();
        #1;
        base = cyc;
        for (int w = 0; w < 10; w++) begin
            logic [3:0] exp_rdy;
            if (w >= 1) bus.m_tready = (w % 2 == 1);
            #1;
            exp_rdy = (w >= 1 && w <= 7 && bus.m_tready) ? 4'b0010 : 4'b0000;
            n_checks++; if (bus.s_tready !== exp_rdy) $display("FAIL bp_s_tready[w%0d]: got %b expected %b", w, bus.s_tready, exp_rdy); else n_pass++;
            cycle();
        end
        bus.m_tready = 1'b1;
        n_checks++;
        if (obs_data.size() !== 4) begin
            $display("FAIL bp_count: got %0d expected 4", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (obs_data[i] !== DW'(16'h1000 + i)) $display("FAIL bp_data[%0d]: got %h expected %h", i, obs_data[i], 16'h1000 + i); else n_pass++;
                n_checks++; if (obs_last[i] !== (i == 3)) $display("FAIL bp_last[%0d]: got %b expected %b", i, obs_last[i], (i == 3)); else n_pass++;
                n_checks++; if (obs_cyc[i] !== 2 * i + 1) $display("FAIL bp_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], 2 * i + 1); else n_pass++;
            end
        end
    endtask

    task automatic test_overlength();
        int exp_cyc [6];
        exp_cyc = '{1, 2, 3, 4, 6, 7};
        do_reset();
        load(0, 6, 32);
        drive_lanes();
        #1;
        base = cyc;
        repeat (10) cycle();
        n_checks++;
        if (obs_data.size() !== 6) begin
            $display("FAIL ol_count: got %0d expected 6", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (obs_tid[i] !== 2'd0) $display("FAIL ol_tid[%0d]: got %0d expected 0", i, obs_tid[i]); else n_pass++;
                n_checks++; if (obs_data[i] !== DW'(i)) $display("FAIL ol_data[%0d]: got %h expected %h", i, obs_data[i], i); else n_pass++;
                n_checks++; if (obs_last[i] !== (i == 3 || i == 5)) $display("FAIL ol_last[%0d]: got %b expected %b", i, obs_last[i], (i == 3 || i == 5)); else n_pass++;
                n_checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL ol_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], exp_cyc[i]); else n_pass++;
            end
            n_checks++; if (obs_err[3] !== 1'b0) $display("FAIL ol_err_early: got %b expected 0", obs_err[3]); else n_pass++;
        end
        n_checks++; if (err_overlen !== 1'b1) $display("FAIL ol_err: got %b expected 1", err_overlen); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd2) $display("FAIL ol_pkt_cnt: got %0d expected 2", pkt_cnt); else n_pass++;
    endtask

    task automatic test_exact_length();
        do_reset();
        load(3, 4, 8);
        drive_lanes();
        #1;
        base = cyc;
        repeat (8) cycle();
        n_checks++;
        if (obs_data.size() !== 4) begin
            $display("FAIL ex_count: got %0d expected 4", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (obs_tid[i] !== 2'd3) $display("FAIL ex_tid[%0d]: got %0d expected 3", i, obs_tid[i]); else n_pass++;
                n_checks++; if (obs_data[i] !== DW'(16'h3000 + i)) $display("FAIL ex_data[%0d]: got %h expected %h", i, obs_data[i], 16'h3000 + i); else n_pass++;
                n_checks++; if (obs_last[i] !== (i == 3)) $display("FAIL ex_last[%0d]: got %b expected %b", i, obs_last[i], (i == 3)); else n_pass++;
            end
        end
        n_checks++; if (err_overlen !== 1'b0) $display("FAIL ex_err: got %b expected 0", err_overlen); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL ex_pkt_cnt: got %0d expected 1", pkt_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        // Beat 0 is a single-beat packet (moves rr_ptr to 1); beats 1..5 form the packet cut by reset.
        load(0, 6, 33);
        drive_lanes();
        #1;
        base = cyc;
        repeat (5) cycle();
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL rm_pre_pkt_cnt: got %0d expected 1", pkt_cnt); else n_pass++;
        n_checks++; if (obs_data.size() !== 3) $display("FAIL rm_pre_count: got %0d expected 3", obs_data.size()); else n_pass++;
        load(1, 2, 2);
        drive_lanes();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.m_tvalid !== 1'b0) $display("FAIL rm_m_tvalid: got %b expected 0", bus.m_tvalid); else n_pass++;
        n_checks++; if (bus.s_tready !== 4'b0000) $display("FAIL rm_s_tready: got %b expected 0000", bus.s_tready); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL rm_pkt_cnt: got %0d expected 0", pkt_cnt); else n_pass++;
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        clear_obs();
        base = cyc;
        repeat (10) cycle();
        n_checks++;
        if (obs_data.size() !== 5) begin
            $display("FAIL rm_count: got %0d expected 5", obs_data.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (obs_tid[i] !== 2'd0) $display("FAIL rm_tid[%0d]: got %0d expected 0", i, obs_tid[i]); else n_pass++;
                n_checks++; if (obs_data[i] !== DW'(3 + i)) $display("FAIL rm_data[%0d]: got %h expected %h", i, obs_data[i], 3 + i); else n_pass++;
                n_checks++; if (obs_last[i] !== (i == 2)) $display("FAIL rm_last[%0d]: got %b expected %b", i, obs_last[i], (i == 2)); else n_pass++;
            end
            n_checks++; if (obs_cyc[0] !== 1) $display("FAIL rm_first_cycle: got %0d expected 1", obs_cyc[0]); else n_pass++;
            n_checks++; if (obs_tid[3] !== 2'd1) $display("FAIL rm_next_tid: got %0d expected 1", obs_tid[3]); else n_pass++;
        end
        n_checks++; if (pkt_cnt !== 32'd2) $display("FAIL rm_post_pkt_cnt: got %0d expected 2", pkt_cnt); else n_pass++;
    endtask

    initial begin
        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        for (int k = 0; k < NL; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        test_reset();
        test_single_lane();
        test_round_robin();
        test_back_pressure();
        test_overlength();
        test_exact_length();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
